classifier_cfg_ctrl: RTL and testbench

Memory-mapped configuration controller for the pixel classifier's 108-bit threshold vector (12 x 9-bit hue bounds). Host writes land in a staging bank. A commit request copies staging into the active bank atomically at the next frame start, so the classifier never sees a mixed configuration within a frame. If video is idle, a timeout forces the copy. Sits between the Avalon-MM control bus and the classifier's classifier_config input.

---
 rtl/classifier_pkg.sv | 24 ++
 rtl/cfg_timeout_ctr.sv | 29 ++
 rtl/classifier_cfg_ctrl.sv | 155 +++++++++++++++
 tb/tb_classifier_cfg_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/classifier_pkg.sv
// classifier_pkg: shared constants and types for the classifier configuration
// controller. Holds the slot geometry, the register map, the two-state FSM
// encoding and the power-up threshold vector.
package classifier_pkg;

    localparam int HUE_W     = 9;
    localparam int NUM_SLOTS = 12;
    localparam int CFG_W     = HUE_W * NUM_SLOTS;

    // Register map (word addresses); 0..NUM_SLOTS-1 are the staging slots
    localparam logic [3:0] ADDR_CTRL   = 4'd12;
    localparam logic [3:0] ADDR_STATUS = 4'd13;
    localparam logic [3:0] ADDR_GEN    = 4'd14;
    localparam logic [3:0] ADDR_ACT0   = 4'd15;

    typedef enum logic {IDLE, PENDING} state_t;

    // Slot 0 sits in the MSBs
    localparam logic [CFG_W-1:0] DEFAULT_CFG = {
        9'd330, 9'd270, 9'd250, 9'd200, 9'd180, 9'd160,
        9'd70,  9'd50,  9'd330, 9'd30,  9'd50,  9'd70
    };

endpackage

// File: rtl/cfg_timeout_ctr.sv
// cfg_timeout_ctr: idle timeout for a pending commit.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (takes priority over en)
//   en       : count while asserted
//   tc       : combinational terminal count, high while en and the count
//              equals TERMINAL-1 (i.e. on the TERMINAL-th enabled cycle)
module cfg_timeout_ctr #(
    parameter int TERMINAL = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(TERMINAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/classifier_cfg_ctrl.sv
// classifier_cfg_ctrl: double-banked threshold configuration for the pixel
// classifier. Host writes go to a staging bank; a commit copies staging into
// the active bank on the next frame_sop (or after IDLE_TIMEOUT idle cycles),
// so a frame never sees a mixed configuration.
//   clk, rst              : clock, asynchronous active-high reset
//   s_address/s_write/
//   s_writedata/s_read    : Avalon-MM slave request
//   s_readdata/
//   s_readdatavalid       : read response, 1-cycle latency
//   frame_sop             : first pixel of a frame
//   classifier_config     : active threshold vector, slot 0 in the MSBs
//   cfg_updated           : one-cycle pulse in the cycle after an apply
//   config_gen            : apply counter, wraps 255->0
// Build option: CFG_READBACK_EN enables the read path; without it the read
// outputs are tied to zero.
module classifier_cfg_ctrl #(
    parameter int NUM_SLOTS    = classifier_pkg::NUM_SLOTS,
    parameter int HUE_MAX      = 359,
    parameter int IDLE_TIMEOUT = 1048576
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [3:0]                                s_address,
    input  logic                                      s_write,
    input  logic [31:0]                               s_writedata,
    input  logic                                      s_read,
    output logic [31:0]                               s_readdata,
    output logic                                      s_readdatavalid,
    input  logic                                      frame_sop,
    output logic [classifier_pkg::HUE_W*NUM_SLOTS-1:0] classifier_config,
    output logic                                      cfg_updated,
    output logic [7:0]                                config_gen
);

    import classifier_pkg::*;

    localparam int         W       = HUE_W * NUM_SLOTS;
    localparam logic [3:0] NSLOT4  = 4'(NUM_SLOTS);
    localparam logic [8:0] HUE_LIM = 9'(HUE_MAX);

    state_t         state, state_nxt;
    logic [W-1:0]   staging, active;
    logic           err;
    logic           apply, ctr_clr, tc;
    logic           wr_ctrl, commit, abort, wr_slot;

    assign wr_ctrl = s_write && (s_address == ADDR_CTRL);
    assign commit  = wr_ctrl && s_writedata[0];
    assign abort   = wr_ctrl && s_writedata[1];
    assign wr_slot = s_write && (s_address < NSLOT4);

    assign classifier_config = active;

    cfg_timeout_ctr #(.TERMINAL(IDLE_TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (state == PENDING),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Abort outranks an apply arriving in the same cycle: the host asked to
    // drop the commit, so nothing reaches the active bank.
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        ctr_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (commit && !abort) begin
                    state_nxt = PENDING;
                    ctr_clr   = 1'b1;
                end
            end
            PENDING: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (frame_sop || tc) begin
                    apply     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging     <= DEFAULT_CFG;
            active      <= DEFAULT_CFG;
            cfg_updated <= 1'b0;
            config_gen  <= '0;
            err         <= 1'b0;
        end else begin
            cfg_updated <= apply;
            if (apply) begin
                active     <= staging;
                config_gen <= config_gen + 8'd1;
            end
            if (wr_slot) begin
                if (state == IDLE && s_writedata[8:0] <= HUE_LIM) begin
                    for (int k = 0; k < NUM_SLOTS; k++)
                        if (s_address == 4'(k))
                            staging[HUE_W*(NUM_SLOTS-1-k) +: HUE_W] <= s_writedata[8:0];
                end else begin
                    err <= 1'b1;
                end
            end
            if (s_write && s_address == ADDR_STATUS && s_writedata[1])
                err <= 1'b0;
        end
    end

`ifdef CFG_READBACK_EN
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (s_address < NSLOT4) begin
            for (int k = 0; k < NUM_SLOTS; k++)
                if (s_address == 4'(k))
                    rd_mux = 32'(staging[HUE_W*(NUM_SLOTS-1-k) +: HUE_W]);
        end else if (s_address == ADDR_STATUS) begin
            rd_mux = {30'd0, err, state == PENDING};
        end else if (s_address == ADDR_GEN) begin
            rd_mux = {24'd0, config_gen};
        end else if (s_address == ADDR_ACT0) begin
            rd_mux = 32'(active[W-1 -: HUE_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
        end else begin
            s_readdatavalid <= s_read;
            if (s_read) s_readdata <= rd_mux;
        end
    end
`else
    assign s_readdata      = '0;
    assign s_readdatavalid = 1'b0;
`endif

    // Upper write-data bits carry nothing in this register map.
    logic unused_bits;
    assign unused_bits = &{1'b0, s_read, s_writedata[31:9]};

endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// tb_classifier_cfg_ctrl: directed self-checking bench for
// classifier_cfg_ctrl, built with IDLE_TIMEOUT = 16.
module tb_classifier_cfg_ctrl;

    localparam logic [107:0] DEF = {
        9'd330, 9'd270, 9'd250, 9'd200, 9'd180, 9'd160,
        9'd70,  9'd50,  9'd330, 9'd30,  9'd50,  9'd70
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_address = '0;
    logic         s_write = 1'b0;
    logic [31:0]  s_writedata = '0;
    logic         s_read = 1'b0;
    logic [31:0]  s_readdata;
    logic         s_readdatavalid;
    logic         frame_sop = 1'b0;
    logic [107:0] classifier_config;
    logic         cfg_updated;
    logic [7:0]   config_gen;

    int checks = 0;
    int errors = 0;
    logic [107:0] exp_cfg;

    classifier_cfg_ctrl #(.NUM_SLOTS(12), .HUE_MAX(359), .IDLE_TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_address         (s_address),
        .s_write           (s_write),
        .s_writedata       (s_writedata),
        .s_read            (s_read),
        .s_readdata        (s_readdata),
        .s_readdatavalid   (s_readdatavalid),
        .frame_sop         (frame_sop),
        .classifier_config (classifier_config),
        .cfg_updated       (cfg_updated),
        .config_gen        (config_gen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic sop();
        @(negedge clk);
        frame_sop = 1'b1;
        @(negedge clk);
        frame_sop = 1'b0;
    endtask

`ifdef CFG_READBACK_EN
    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        s_address = a; s_read = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, 108'(s_readdatavalid), 108'(1));
        check(tag, 108'(s_readdata), 108'(exp));
        @(negedge clk);
        s_read = 1'b0;
    endtask
`endif

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_cfg_during", classifier_config, DEF);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg", classifier_config, DEF);
        check("rst_gen", 108'(config_gen), 108'(0));
        check("rst_upd", 108'(cfg_updated), 108'(0));
        check("rst_rdata", 108'(s_readdata), 108'(0));
        check("rst_rvld", 108'(s_readdatavalid), 108'(0));

        // Staged apply: slot0 = 300, slot11 = 10
        exp_cfg = DEF;
        exp_cfg[107:99] = 9'd300;
        exp_cfg[8:0]    = 9'd10;
        wr(4'd0, 32'd300);
        wr(4'd11, 32'd10);
        check("stage_no_leak", classifier_config, DEF);
        wr(4'd12, 32'd1);
        check("commit_pending", 108'(dut.state), 108'(1));
        repeat (4) @(negedge clk);
        check("hold_before_sop", classifier_config, DEF);
        frame_sop = 1'b1;
        @(posedge clk);
        #1;
        check("apply_cfg", classifier_config, exp_cfg);
        check("apply_upd", 108'(cfg_updated), 108'(1));
        check("apply_gen", 108'(config_gen), 108'(1));
        @(negedge clk);
        frame_sop = 1'b0;
        @(negedge clk);
        check("upd_one_cycle", 108'(cfg_updated), 108'(0));
        check("apply_idle", 108'(dut.state), 108'(0));

        // Illegal value, boundary value, err clear
        wr(4'd3, 32'd400);
        check("illegal_slot3", 108'(dut.staging[72 +: 9]), 108'(200));
        check("illegal_err", 108'(dut.err), 108'(1));
`ifdef CFG_READBACK_EN
        rd("rd_status", 4'd13, 32'd2);
        rd("rd_gen", 4'd14, 32'd1);
        rd("rd_act0", 4'd15, 32'd300);
        rd("rd_slot11", 4'd11, 32'd10);
`endif
        wr(4'd13, 32'd2);
        check("err_clear", 108'(dut.err), 108'(0));
        wr(4'd4, 32'd359);
        check("max_slot4", 108'(dut.staging[63 +: 9]), 108'(359));
        check("max_no_err", 108'(dut.err), 108'(0));
        exp_cfg[63 +: 9] = 9'd359;

        // Pending lock
        wr(4'd12, 32'd1);
        wr(4'd2, 32'd100);
        check("lock_slot2", 108'(dut.staging[81 +: 9]), 108'(250));
        check("lock_err", 108'(dut.err), 108'(1));
        sop();
        check("lock_apply_cfg", classifier_config, exp_cfg);
        check("lock_apply_gen", 108'(config_gen), 108'(2));
        wr(4'd13, 32'd2);

        // Timeout: apply on the 16th cycle after the commit edge
        wr(4'd12, 32'd1);
        repeat (15) @(negedge clk);
        check("to_not_early_gen", 108'(config_gen), 108'(2));
        check("to_not_early_upd", 108'(cfg_updated), 108'(0));
        @(posedge clk);
        #1;
        check("to_gen", 108'(config_gen), 108'(3));
        check("to_upd", 108'(cfg_updated), 108'(1));
        check("to_cfg", classifier_config, exp_cfg);

        // Abort, commit+abort, double commit, sop in IDLE
        wr(4'd12, 32'd1);
        wr(4'd12, 32'd2);
        check("abort_idle", 108'(dut.state), 108'(0));
        sop();
        check("abort_gen", 108'(config_gen), 108'(3));
        wr(4'd12, 32'd3);
        check("both_idle", 108'(dut.state), 108'(0));
        wr(4'd12, 32'd1);
        wr(4'd12, 32'd1);
        check("dbl_commit_err", 108'(dut.err), 108'(0));
        check("dbl_commit_pend", 108'(dut.state), 108'(1));
        sop();
        check("dbl_commit_gen", 108'(config_gen), 108'(4));
        sop();
        check("idle_sop_gen", 108'(config_gen), 108'(4));

        // Reset mid-pending
        wr(4'd1, 32'd5);
        wr(4'd12, 32'd1);
        check("pre_rst_pend", 108'(dut.state), 108'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_cfg", classifier_config, DEF);
        check("rst_mid_state", 108'(dut.state), 108'(0));
        check("rst_mid_gen", 108'(config_gen), 108'(0));
        check("rst_mid_stage", dut.staging, DEF);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
